if_id_skid_buffer: RTL
======================

IF_ID_SKID_BUFFER -- requirements
Module: if_id_skid_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the PC width.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: fetch stage presents a valid instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: buffer can accept this cycle.
REQ-007 The block SHALL have port in_pc, input, ADDR_WIDTH bits: PC of the fetched instruction.
REQ-008 The block SHALL have port in_instr, input, DATA_WIDTH bits: fetched instruction word.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all buffered and incoming entries.
REQ-010 The block SHALL have port out_valid, output, 1 bit: head entry valid toward decode.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode accepts the head entry.
REQ-012 The block SHALL have port out_pc, output, ADDR_WIDTH bits: PC of the head entry.
REQ-013 The block SHALL have port out_instr, output, DATA_WIDTH bits: instruction of the head entry.
REQ-014 The block SHALL have port occupancy, output, 2 bits: number of held entries (0..2).

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 The block SHALL implement states EMPTY, ONE and TWO, each holding 0, 1 or 2 entries (head register plus skid register).
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO, decoded from registered state only with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly in ONE and TWO; out_pc/out_instr SHALL always drive the head register.
REQ-019 Transitions: EMPTY+push->ONE, head=input; EMPTY+no push->EMPTY.
REQ-020 Transitions: ONE+push+pop->ONE, head=input; ONE+push only->TWO, skid=input; ONE+pop only->EMPTY; ONE+neither->ONE.
REQ-021 Transitions: TWO+pop->ONE, head=skid; TWO+no pop->TWO; push is impossible in TWO.
REQ-022 Latency SHALL be one cycle: an entry pushed into EMPTY at edge N is on the outputs with out_valid=1 after edge N.
REQ-023 Entries SHALL leave in push order, with none lost or duplicated absent flush.
REQ-024 Head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 Flush SHALL have top priority: on an edge with flush=1 the state SHALL become EMPTY, and a simultaneous push or pop SHALL have no effect.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/ONE/TWO.
REQ-027 Data registers SHALL not be required to clear on pop or flush; only validity is tracked by state.

Reset
REQ-028 While reset=1, independent of clock, the state SHALL be EMPTY, out_valid=0, occupancy=0, out_pc=0 and out_instr=0.
REQ-029 While reset=1, in_ready SHALL be 1, per REQ-017.
REQ-030 Reset asserted mid-operation SHALL discard all entries immediately.
REQ-031 The first push SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 The bench SHALL cover: reset, then push pc=0x0, instr=0x00000013 with out_ready=1 -> next cycle out_valid=1, out_pc=0x0, occupancy=1.
REQ-033 The bench SHALL cover: out_ready=0 with pushes pc=0x4 then pc=0x8 -> occupancy=2, in_ready=0, out_pc=0x4 held; then out_ready=1 for two cycles -> 0x4 then 0x8 delivered, then EMPTY.
REQ-034 The bench SHALL cover: ONE state with simultaneous push pc=0xC and pop -> occupancy stays 1 and out_pc=0xC next cycle.
REQ-035 The bench SHALL cover: TWO state with flush=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, input not captured.
REQ-036 The bench SHALL cover: reset pulsed asynchronously between edges while in TWO -> out_valid=0 and occupancy=0 before the next edge.
REQ-037 The bench SHALL cover: random in_valid/out_ready over 10000 cycles against a reference queue model -> order preserved, no loss, in_ready never 1 in TWO.

Source files
------------

// File: rtl/if_id_skid_buffer.sv
// Two-entry IF/ID pipeline buffer: a head register feeding decode plus a skid register.
// in_ready depends only on registered state, so there is no combinational path from out_ready.
module if_id_skid_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [1:0]            occupancy
);

    // The encoding equals the entry count, so occupancy doubles as the visible FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [DATA_WIDTH-1:0] head_instr_q, head_instr_d;
    logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                  push;
    logic                  pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            head_pc_q    <= '0;
            head_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        in_ready     = (state_q != TWO);
        out_valid    = (state_q == ONE) || (state_q == TWO);
        push         = in_valid && in_ready;
        pop          = out_valid && out_ready;

        if (flush) begin
            // Data registers are left as-is; only validity is tracked by state.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                    end else if (push) begin
                        state_d      = TWO;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d      = ONE;
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign out_pc    = head_pc_q;
    assign out_instr = head_instr_q;
    assign occupancy = state_q;

endmodule
